// File: rtl/dbg_pd_seq_pkg.sv
// Shared types and constants for the debug PD capture sequencer.
package dbg_pd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ARMED,
    ST_SETTLE,
    ST_PRESENT,
    ST_DONE
  } dbg_pd_seq_state_e;

  // Bit positions inside the capture block enable register
  localparam int EN              = 0;
  localparam int CAPTURE_EN      = 1;
  localparam int TRIGGER_EN      = 2;
  localparam int CAPTURE_LAST_EN = 3;

  localparam int CAPTURE_CNT_WIDTH = 16;

endpackage

// File: rtl/dbg_pd_seq_timer.sv
// Loadable down-counter. It is shared by the ARMED timeout and the SETTLE
// mux-latency wait; it holds at zero once it gets there.
module dbg_pd_seq_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // Load has priority; otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (!rstn)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dbg_pd_capture_seq.sv
// Debug PD capture sequencer: arm -> capture -> word-by-word readout.
// Optional build macro DBG_PD_SEQ_AUTO_REARM_EN: DONE re-enters CLEAR so
// captures repeat until sw_abort; without it DONE returns to IDLE.
module dbg_pd_capture_seq
  import dbg_pd_seq_pkg::*;
#(
  parameter int PD_WIDTH      = 100,
  parameter int NUM_WORDS     = (PD_WIDTH + 31) / 32,
  parameter int SEL_WIDTH     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  parameter int MUX_LATENCY   = 2,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         sw_arm,
  input  logic                         sw_abort,
  input  logic                         cfg_trigger_en,
  input  logic                         cfg_capture_last,
  input  logic [TIMEOUT_WIDTH-1:0]     cfg_timeout,
  input  logic                         capture_match_i,
  input  logic [31:0]                  pd_word_i,
  output logic [3:0]                   en_reg_o,
  output logic [SEL_WIDTH-1:0]         word_sel_o,
  output logic                         rd_valid_o,
  output logic [31:0]                  rd_data_o,
  output logic [SEL_WIDTH-1:0]         rd_idx_o,
  input  logic                         rd_ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         timeout_o,
  output logic [CAPTURE_CNT_WIDTH-1:0] capture_cnt_o
);

  localparam logic [SEL_WIDTH-1:0]     LAST_SEL    = SEL_WIDTH'(NUM_WORDS - 1);
  // Timer counts down to zero inclusive, so load one less than the wait
  localparam logic [TIMEOUT_WIDTH-1:0] SETTLE_LOAD = TIMEOUT_WIDTH'(MUX_LATENCY - 1);

  dbg_pd_seq_state_e          state, state_nxt;
  logic                       tmr_load, tmr_zero, tmo_hit, hs;
  logic [TIMEOUT_WIDTH-1:0]   tmr_val;
  logic [3:0]                 en_nxt;

  dbg_pd_seq_timer #(.WIDTH(TIMEOUT_WIDTH)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, timer control and enable-register decode
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmo_hit   = 1'b0;
    hs        = rd_valid_o && rd_ready_i;
    case (state)
      ST_IDLE:    if (sw_arm) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        state_nxt = ST_ARMED;
        tmr_load  = 1'b1;
        tmr_val   = cfg_timeout;
      end
      ST_ARMED: begin
        // A match wins over a timeout expiring in the same cycle
        if (capture_match_i) begin
          state_nxt = ST_SETTLE;
          tmr_load  = 1'b1;
          tmr_val   = SETTLE_LOAD;
        end else if ((cfg_timeout != '0) && tmr_zero) begin
          state_nxt = ST_IDLE;
          tmo_hit   = 1'b1;
        end
      end
      ST_SETTLE:  if (tmr_zero) state_nxt = ST_PRESENT;
      ST_PRESENT: begin
        if (hs) begin
          if (word_sel_o == LAST_SEL) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_SETTLE;
            tmr_load  = 1'b1;
            tmr_val   = SETTLE_LOAD;
          end
        end
      end
      ST_DONE: begin
`ifdef DBG_PD_SEQ_AUTO_REARM_EN
        state_nxt = ST_CLEAR;
`else
        state_nxt = ST_IDLE;
`endif
      end
      default:    state_nxt = ST_IDLE;
    endcase
    if (sw_abort) begin
      state_nxt = ST_IDLE;
      tmo_hit   = 1'b0;
    end

    en_nxt = 4'b0000;
    case (state_nxt)
      ST_CLEAR: begin
        en_nxt[EN]              = 1'b1;
        en_nxt[TRIGGER_EN]      = cfg_trigger_en;
        en_nxt[CAPTURE_LAST_EN] = cfg_capture_last;
      end
      ST_ARMED: begin
        en_nxt[EN]              = 1'b1;
        en_nxt[CAPTURE_EN]      = 1'b1;
        en_nxt[TRIGGER_EN]      = cfg_trigger_en;
        en_nxt[CAPTURE_LAST_EN] = cfg_capture_last;
      end
      // capture_en low freezes the captured PD while it is read out
      ST_SETTLE, ST_PRESENT: en_nxt[EN] = 1'b1;
      default:               en_nxt     = 4'b0000;
    endcase
  end

  // Registered outputs, decoded from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      en_reg_o      <= '0;
      word_sel_o    <= '0;
      rd_valid_o    <= 1'b0;
      rd_data_o     <= '0;
      rd_idx_o      <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      capture_cnt_o <= '0;
    end else begin
      en_reg_o   <= en_nxt;
      busy_o     <= (state_nxt != ST_IDLE);
      done_o     <= (state_nxt == ST_DONE);
      rd_valid_o <= (state_nxt == ST_PRESENT);

      if (state == ST_IDLE && state_nxt == ST_CLEAR) timeout_o <= 1'b0;
      else if (tmo_hit)                              timeout_o <= 1'b1;

      if (state_nxt == ST_DONE && capture_cnt_o != '1)
        capture_cnt_o <= capture_cnt_o + 1'b1;

      if (state_nxt == ST_IDLE || (state == ST_ARMED && state_nxt == ST_SETTLE))
        word_sel_o <= '0;
      else if (state == ST_PRESENT && state_nxt == ST_SETTLE)
        word_sel_o <= word_sel_o + 1'b1;

      // Latch the word once the mux has settled; held through any stall
      if (state == ST_SETTLE && state_nxt == ST_PRESENT) begin
        rd_data_o <= pd_word_i;
        rd_idx_o  <= word_sel_o;
      end
    end
  end

endmodule

// File: tb/tb_dbg_pd_capture_seq.sv
// Directed bench for dbg_pd_capture_seq: a per-cycle vector table for a full
// capture, plus sequences for stall, timeout, abort and match/timeout races.
module tb_dbg_pd_capture_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sw_arm, sw_abort, cfg_trigger_en, cfg_capture_last;
  logic [15:0] cfg_timeout;
  logic        capture_match_i;
  logic [31:0] pd_word_i;
  logic [3:0]  en_reg_o;
  logic [1:0]  word_sel_o, rd_idx_o;
  logic        rd_valid_o, rd_ready_i, busy_o, done_o, timeout_o;
  logic [31:0] rd_data_o;
  logic [15:0] capture_cnt_o;

  int nvec = 0;
  int nerr = 0;

  localparam logic [99:0] PD = 100'h9_0123_4567_89AB_CDEF_FEDC_BA98;

  always #5 clk = ~clk;

  dbg_pd_capture_seq dut (
    .clk(clk), .rstn(rstn), .sw_arm(sw_arm), .sw_abort(sw_abort),
    .cfg_trigger_en(cfg_trigger_en), .cfg_capture_last(cfg_capture_last),
    .cfg_timeout(cfg_timeout), .capture_match_i(capture_match_i),
    .pd_word_i(pd_word_i), .en_reg_o(en_reg_o), .word_sel_o(word_sel_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_idx_o(rd_idx_o),
    .rd_ready_i(rd_ready_i), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .capture_cnt_o(capture_cnt_o)
  );

  function automatic logic [31:0] word_of(input int i);
    logic [127:0] p;
    p = {28'd0, PD};
    return p[32*i +: 32];
  endfunction

  // Capture mux model: one register stage behind word_sel_o
  always_ff @(posedge clk) pd_word_i <= word_of(int'(word_sel_o));

  typedef struct {
    logic arm, abort, match, ready;
    logic busy, valid;
    logic [1:0] idx;
    logic done;
    logic [3:0] en;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic arm, abort, match, ready, busy, valid,
                              input logic [1:0] idx, input logic done,
                              input logic [3:0] en, input logic [15:0] cnt);
    vec_t v;
    v.arm = arm; v.abort = abort; v.match = match; v.ready = ready;
    v.busy = busy; v.valid = valid; v.idx = idx; v.done = done;
    v.en = en; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    sw_arm = 1'b1; step(); sw_arm = 1'b0;
  endtask

  task automatic go_idle();
    sw_abort = 1'b1; step(); sw_abort = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rd_valid_o) begin ok = 1'b1; break; end
      step();
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  initial begin
    rstn = 1'b0; sw_arm = 1'b0; sw_abort = 1'b0; capture_match_i = 1'b0;
    cfg_trigger_en = 1'b1; cfg_capture_last = 1'b0; cfg_timeout = 16'd0;
    rd_ready_i = 1'b1;
    repeat (3) step();
    chk("rst_en",      64'(en_reg_o),      64'd0);
    chk("rst_wsel",    64'(word_sel_o),    64'd0);
    chk("rst_valid",   64'(rd_valid_o),    64'd0);
    chk("rst_data",    64'(rd_data_o),     64'd0);
    chk("rst_idx",     64'(rd_idx_o),      64'd0);
    chk("rst_busy",    64'(busy_o),        64'd0);
    chk("rst_done",    64'(done_o),        64'd0);
    chk("rst_timeout", 64'(timeout_o),     64'd0);
    chk("rst_cnt",     64'(capture_cnt_o), 64'd0);
    rstn = 1'b1;
    step();

    // Full capture: arm, match 10 cycles later, four words back-to-back
    add(1,0,0,1, 1,0,2'd0,0,4'h5,16'd0);                 // CLEAR
    for (int i = 1; i <= 9; i++) add(0,0,0,1, 1,0,2'd0,0,4'h7,16'd0); // ARMED
    add(0,0,1,1, 1,0,2'd0,0,4'h1,16'd0);                 // match -> SETTLE
    add(0,0,0,1, 1,0,2'd0,0,4'h1,16'd0);
    for (int w = 0; w < 4; w++) begin
      add(0,0,0,1, 1,1,2'(w),0,4'h1,16'd0);              // PRESENT word w
      if (w < 3) begin
        add(0,0,0,1, 1,0,2'(w),0,4'h1,16'd0);
        add(0,0,0,1, 1,0,2'(w),0,4'h1,16'd0);
      end
    end
    add(0,0,0,1, 1,0,2'd3,1,4'h0,16'd1);                 // DONE
`ifdef DBG_PD_SEQ_AUTO_REARM_EN
    add(0,0,0,1, 1,0,2'd3,0,4'h5,16'd1);                 // back to CLEAR
`else
    add(0,0,0,1, 0,0,2'd3,0,4'h0,16'd1);                 // IDLE
`endif
    foreach (tbl[i]) begin
      sw_arm = tbl[i].arm; sw_abort = tbl[i].abort;
      capture_match_i = tbl[i].match; rd_ready_i = tbl[i].ready;
      step();
      chk($sformatf("vec%0d", i),
          {busy_o, rd_valid_o, rd_idx_o, done_o, en_reg_o, capture_cnt_o},
          {tbl[i].busy, tbl[i].valid, tbl[i].idx, tbl[i].done, tbl[i].en, tbl[i].cnt});
      if (tbl[i].valid) chk($sformatf("vec%0d_data", i), 64'(rd_data_o), 64'(word_of(int'(tbl[i].idx))));
    end
    sw_arm = 1'b0; capture_match_i = 1'b0;
    go_idle();

    // Stall on word 2: data and index must hold, no word skipped
    rd_ready_i = 1'b1;
    pulse_arm(); step();
    capture_match_i = 1'b1; step(); capture_match_i = 1'b0;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (rd_valid_o && rd_idx_o == 2'd2) begin found = 1'b1; break; end
        step();
      end
      chk("stall_reach_w2", 64'(found), 64'd1);
    end
    rd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 64'(rd_valid_o), 64'd1);
      chk("stall_idx",   64'(rd_idx_o),   64'd2);
      chk("stall_wsel",  64'(word_sel_o), 64'd2);
      chk("stall_data",  64'(rd_data_o),  64'(word_of(2)));
    end
    rd_ready_i = 1'b1;
    step();
    chk("stall_release", 64'(rd_valid_o), 64'd0);
    wait_valid("stall_w3_valid");
    chk("stall_w3_idx",  64'(rd_idx_o),  64'd3);
    chk("stall_w3_data", 64'(rd_data_o), 64'(word_of(3)));
    step();
    chk("stall_done", 64'(done_o),        64'd1);
    chk("stall_cnt",  64'(capture_cnt_o), 64'd2);
    go_idle();

    // Timeout of 20: flag sets 21 cycles after ARMED is entered
    cfg_timeout = 16'd20; cfg_trigger_en = 1'b0; cfg_capture_last = 1'b1;
    pulse_arm();
    chk("tmo_clear_en", 64'(en_reg_o), 64'h9);
    step();
    chk("tmo_armed_en", 64'(en_reg_o), 64'hB);
    for (int k = 1; k <= 20; k++) step();
    chk("tmo_not_yet", 64'(timeout_o), 64'd0);
    step();
    chk("tmo_set",  64'(timeout_o), 64'd1);
    chk("tmo_busy", 64'(busy_o),    64'd0);
    chk("tmo_en",   64'(en_reg_o),  64'd0);
    step(); step();
    chk("tmo_sticky", 64'(timeout_o), 64'd1);

    // Abort in the same cycle as a match
    cfg_timeout = 16'd0; cfg_trigger_en = 1'b1; cfg_capture_last = 1'b0;
    pulse_arm();
    chk("arm_clears_tmo", 64'(timeout_o), 64'd0);
    step();
    capture_match_i = 1'b1; sw_abort = 1'b1;
    step();
    capture_match_i = 1'b0; sw_abort = 1'b0;
    chk("abort_busy",  64'(busy_o),     64'd0);
    chk("abort_valid", 64'(rd_valid_o), 64'd0);
    chk("abort_en",    64'(en_reg_o),   64'd0);
    chk("abort_wsel",  64'(word_sel_o), 64'd0);
    step(); step(); step();
    chk("abort_no_valid", 64'(rd_valid_o),    64'd0);
    chk("abort_cnt",      64'(capture_cnt_o), 64'd2);

    // Match lands in the cycle the timeout expires: readout wins
    cfg_timeout = 16'd5;
    pulse_arm(); step();
    for (int k = 0; k < 5; k++) step();
    capture_match_i = 1'b1; step(); capture_match_i = 1'b0;
    chk("race_busy", 64'(busy_o),    64'd1);
    chk("race_en",   64'(en_reg_o),  64'h1);
    chk("race_tmo",  64'(timeout_o), 64'd0);
    begin
      int words, dones;
      words = 0; dones = 0;
      for (int i = 0; i < 60 && dones == 0; i++) begin
        step();
        if (rd_valid_o) words++;
        if (done_o) dones++;
      end
      chk("race_words", 64'(words), 64'd4);
      chk("race_done",  64'(dones), 64'd1);
    end
    chk("race_tmo_end", 64'(timeout_o),     64'd0);
    chk("race_cnt",     64'(capture_cnt_o), 64'd3);
    go_idle();

`ifdef DBG_PD_SEQ_AUTO_REARM_EN
    // Continuous capture: three bursts, each after a CLEAR cycle
    cfg_timeout = 16'd0;
    begin
      int clears, words, dones;
      clears = 0; words = 0; dones = 0;
      pulse_arm();
      for (int i = 0; i < 300; i++) begin
        if (en_reg_o == 4'h5) clears++;
        if (rd_valid_o) words++;
        if (done_o) dones++;
        if (dones == 3) break;
        capture_match_i = (en_reg_o == 4'h7);
        step();
      end
      capture_match_i = 1'b0;
      chk("rearm_busy",   64'(busy_o), 64'd1);
      go_idle();
      chk("rearm_clears", 64'(clears), 64'd3);
      chk("rearm_words",  64'(words),  64'd12);
      chk("rearm_dones",  64'(dones),  64'd3);
      chk("rearm_cnt",    64'(capture_cnt_o), 64'd6);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
